// File: rtl/seg7_display_scheduler.sv
// Time-shares one 4-digit seven-segment driver between operand A, operand B and the FMA result.
// Optional feature macro: SEG7_RESULT_PRIORITY_EN (a new result preempts rotation and stepping).
module seg7_display_scheduler #(
   parameter int DWELL_CYCLES = 200_000_000,
   parameter int DATA_W       = 16
) (
   input  logic              clk_100MHz,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   input  logic              r_valid,
   input  logic [DATA_W-1:0] r_data,
   input  logic              auto_en,
   input  logic              step,
   output logic              dm_write,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        src_sel,
   output logic [2:0]        src_fresh
);

`ifdef SEG7_RESULT_PRIORITY_EN
   localparam logic RESULT_PRIORITY = 1'b1;
`else
   localparam logic RESULT_PRIORITY = 1'b0;
`endif

   localparam logic [27:0] TIMER_LAST = 28'(DWELL_CYCLES - 1);
   localparam logic [1:0]  SEL_A      = 2'd0;
   localparam logic [1:0]  SEL_B      = 2'd1;
   localparam logic [1:0]  SEL_R      = 2'd2;

   typedef enum logic {ST_SHOW, ST_DWELL} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] hold_a_q, hold_a_d;
   logic [DATA_W-1:0] hold_b_q, hold_b_d;
   logic [DATA_W-1:0] hold_r_q, hold_r_d;
   logic              dm_write_q, dm_write_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [1:0]        src_sel_q, src_sel_d;
   logic [2:0]        src_fresh_q, src_fresh_d;
   logic [27:0]       timer_q, timer_d;
   logic              pending_q, pending_d;

   logic [DATA_W-1:0] holdSel;
   logic              curValid;
   logic [1:0]        selNext;
   logic [2:0]        freshClr;

   always_comb begin
      holdSel  = '0;
      curValid = 1'b0;
      case (src_sel_q)
         SEL_A: begin holdSel = hold_a_q; curValid = a_valid; end
         SEL_B: begin holdSel = hold_b_q; curValid = b_valid; end
         SEL_R: begin holdSel = hold_r_q; curValid = r_valid; end
         default: begin holdSel = '0; curValid = 1'b0; end
      endcase
      selNext = (src_sel_q == SEL_R) ? SEL_A : src_sel_q + 2'd1;
   end

   // SHOW issues one registered write; DWELL decides what triggers the next SHOW.
   always_comb begin
      state_d    = state_q;
      dm_write_d = 1'b0;
      data_out_d = data_out_q;
      src_sel_d  = src_sel_q;
      timer_d    = timer_q;
      pending_d  = pending_q;
      freshClr   = 3'b000;
      hold_a_d   = a_valid ? a_data : hold_a_q;
      hold_b_d   = b_valid ? b_data : hold_b_q;
      hold_r_d   = r_valid ? r_data : hold_r_q;

      case (state_q)
         ST_SHOW: begin
            dm_write_d = 1'b1;
            data_out_d = holdSel;
            freshClr   = 3'b001 << src_sel_q;
            pending_d  = curValid;
            if (RESULT_PRIORITY && r_valid) begin
               pending_d = 1'b1;
               src_sel_d = SEL_R;
            end
            state_d = ST_DWELL;
         end
         ST_DWELL: begin
            if (RESULT_PRIORITY && r_valid) begin
               src_sel_d = SEL_R;
               timer_d   = '0;
               state_d   = ST_SHOW;
            end else if (step) begin
               src_sel_d = selNext;
               timer_d   = '0;
               state_d   = ST_SHOW;
            end else if (pending_q || curValid) begin
               state_d = ST_SHOW;
            end else if (auto_en && (timer_q == TIMER_LAST)) begin
               src_sel_d = selNext;
               timer_d   = '0;
               state_d   = ST_SHOW;
            end else if (auto_en) begin
               timer_d = timer_q + 28'd1;
            end
         end
         default: state_d = ST_SHOW;
      endcase

      // A capture in the same cycle as its SHOW keeps the fresh flag set.
      src_fresh_d = (src_fresh_q & ~freshClr) | {r_valid, b_valid, a_valid};
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q     <= ST_SHOW;
         hold_a_q    <= '0;
         hold_b_q    <= '0;
         hold_r_q    <= '0;
         dm_write_q  <= 1'b0;
         data_out_q  <= '0;
         src_sel_q   <= SEL_A;
         src_fresh_q <= 3'b000;
         timer_q     <= '0;
         pending_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_a_q    <= hold_a_d;
         hold_b_q    <= hold_b_d;
         hold_r_q    <= hold_r_d;
         dm_write_q  <= dm_write_d;
         data_out_q  <= data_out_d;
         src_sel_q   <= src_sel_d;
         src_fresh_q <= src_fresh_d;
         timer_q     <= timer_d;
         pending_q   <= pending_d;
      end
   end

   assign dm_write  = dm_write_q;
   assign data_out  = data_out_q;
   assign src_sel   = src_sel_q;
   assign src_fresh = src_fresh_q;

endmodule

// File: tb/tb_seg7_display_scheduler.sv
// Self-checking bench for seg7_display_scheduler: directed scenarios plus a randomized run,
// all compared every cycle against a behavioural model of the display rotation rules.
module tb_seg7_display_scheduler;

   localparam int DWELL = 8;
`ifdef SEG7_RESULT_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid, r_valid;
   logic [15:0] a_data, b_data, r_data;
   logic        auto_en, step;
   logic        dm_write;
   logic [15:0] data_out;
   logic [1:0]  src_sel;
   logic [2:0]  src_fresh;

   always #5 clk = ~clk;

   seg7_display_scheduler #(.DWELL_CYCLES(DWELL), .DATA_W(16)) dut (
      .clk_100MHz(clk),
      .reset     (reset),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .r_valid   (r_valid),
      .r_data    (r_data),
      .auto_en   (auto_en),
      .step      (step),
      .dm_write  (dm_write),
      .data_out  (data_out),
      .src_sel   (src_sel),
      .src_fresh (src_fresh)
   );

   int tests = 0;
   int failures = 0;
   int cycleNum = 0;
   bit prevWrite = 0;

   // Behavioural view: which source is on screen, whether a write is due, and what each holds.
   logic [15:0] mHold [3];
   bit          mFresh [3];
   int          mSel, mTimer;
   bit          mShowing, mPending, mWrite;
   logic [15:0] mData;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%h expected=0x%h (cycle %0d)", tag, obs, exp, cycleNum);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         mHold[i]  = 16'h0000;
         mFresh[i] = 1'b0;
      end
      mSel = 0; mTimer = 0; mShowing = 1; mPending = 0; mWrite = 0; mData = 16'h0000;
   endtask

   task automatic modelStep(input bit av, input logic [15:0] ad, input bit bv, input logic [15:0] bd,
                            input bit rv, input logic [15:0] rd, input bit st, input bit au);
      bit vld [3];
      bit cur;
      vld[0] = av; vld[1] = bv; vld[2] = rv;
      cur = vld[mSel];
      if (mShowing) begin
         mWrite       = 1;
         mData        = mHold[mSel];
         mFresh[mSel] = 0;
         mPending     = cur;
         if (PRIO && rv) begin
            mPending = 1;
            mSel     = 2;
         end
         mShowing = 0;
      end else begin
         mWrite = 0;
         if (PRIO && rv) begin
            mSel = 2; mTimer = 0; mShowing = 1;
         end else if (st) begin
            mSel = (mSel + 1) % 3; mTimer = 0; mShowing = 1;
         end else if (mPending || cur) begin
            mShowing = 1;
         end else if (au && mTimer == DWELL - 1) begin
            mSel = (mSel + 1) % 3; mTimer = 0; mShowing = 1;
         end else if (au) begin
            mTimer++;
         end
      end
      if (av) begin mHold[0] = ad; mFresh[0] = 1; end
      if (bv) begin mHold[1] = bd; mFresh[1] = 1; end
      if (rv) begin mHold[2] = rd; mFresh[2] = 1; end
   endtask

   task automatic checkOutput();
      check("dm_write", 16'(dm_write), 16'(mWrite));
      check("data_out", data_out, mData);
      check("src_sel", 16'(src_sel), 16'(mSel));
      check("src_fresh", 16'(src_fresh), 16'({mFresh[2], mFresh[1], mFresh[0]}));
      if (prevWrite) check("no_back_to_back_write", 16'(dm_write), 16'h0000);
      prevWrite = dm_write;
   endtask

   task automatic applyStimulus(input bit av, input logic [15:0] ad, input bit bv, input logic [15:0] bd,
                                input bit rv, input logic [15:0] rd, input bit st);
      a_valid = av; a_data = ad;
      b_valid = bv; b_data = bd;
      r_valid = rv; r_data = rd;
      step    = st;
      @(posedge clk);
      cycleNum++;
      modelStep(av, ad, bv, bd, rv, rd, st, auto_en);
      #1;
      checkOutput();
      a_valid = 0; b_valid = 0; r_valid = 0; step = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      #1;
      modelReset();
      prevWrite = 0;
      checkOutput();
      repeat (2) @(posedge clk);
      #1;
      checkOutput();
      reset = 1'b0;
   endtask

   task automatic stepToSel(input int target);
      for (int i = 0; i < 4 && mSel != target; i++) begin
         applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 1);
         idle(2);
      end
      check("reach_sel", 16'(mSel), 16'(target));
   endtask

   initial begin
      int          writes;
      int          wCycle [4];
      logic [15:0] wData [4];
      logic [1:0]  wSel [4];
      logic [15:0] table3 [3];
      int          selBefore;
      bit          sawResult;

      reset = 1; a_valid = 0; b_valid = 0; r_valid = 0; step = 0; auto_en = 0;
      a_data = 0; b_data = 0; r_data = 0;
      #2;
      doReset();

      // Reset release: one write of source A with 0x0000, then silence.
      applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 0);
      check("first_write_strobe", 16'(dm_write), 16'h0001);
      check("first_write_data", data_out, 16'h0000);
      check("first_write_sel", 16'(src_sel), 16'h0000);
      writes = 0;
      for (int i = 0; i < 100; i++) begin
         idle(1);
         if (dm_write) writes++;
      end
      check("quiet_after_reset", 16'(writes), 16'h0000);

      // Auto rotation through three captured values.
      table3[0] = 16'h3F80; table3[1] = 16'h4000; table3[2] = 16'h4040;
      applyStimulus(1, 16'h3F80, 0, 16'h0, 0, 16'h0, 0);
      applyStimulus(0, 16'h0, 1, 16'h4000, 0, 16'h0, 0);
      applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h4040, 0);
      idle(3);
      auto_en = 1;
      writes = 0;
      for (int i = 0; i < 60 && writes < 4; i++) begin
         idle(1);
         if (dm_write) begin
            wCycle[writes] = cycleNum; wData[writes] = data_out; wSel[writes] = src_sel;
            writes++;
         end
      end
      check("auto_write_count", 16'(writes), 16'h0004);
      for (int i = 1; i < 4; i++) begin
         check("auto_gap", 16'(wCycle[i] - wCycle[i-1]), 16'(DWELL + 1));
         check("auto_sel_order", 16'(wSel[i]), 16'((int'(wSel[i-1]) + 1) % 3));
      end
      for (int i = 0; i < 4; i++) check("auto_data", wData[i], table3[wSel[i] % 3]);

      // Manual step from B to R.
      auto_en = 0;
      stepToSel(1);
      applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 1);
      idle(1);
      check("step_write", 16'(dm_write), 16'h0001);
      check("step_sel", 16'(src_sel), 16'h0002);
      check("step_data", data_out, 16'h4040);

      // Step coincident with timer expiry advances by exactly one.
      idle(2);
      auto_en = 1;
      for (int i = 0; i < 20 && !(!mShowing && mTimer == DWELL - 1); i++) idle(1);
      selBefore = src_sel;
      applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 1);
      check("step_expiry_sel", 16'(src_sel), 16'((selBefore + 1) % 3));
      idle(2);

      // Refresh on capture of the shown source, and capture during SHOW.
      auto_en = 0;
      stepToSel(0);
      applyStimulus(1, 16'hC000, 0, 16'h0, 0, 16'h0, 0);
      idle(1);
      check("refresh_write", 16'(dm_write), 16'h0001);
      check("refresh_data", data_out, 16'hC000);
      check("refresh_sel", 16'(src_sel), 16'h0000);
      idle(2);
      applyStimulus(1, 16'hC100, 0, 16'h0, 0, 16'h0, 0);
      applyStimulus(1, 16'hC200, 0, 16'h0, 0, 16'h0, 0);
      check("show_old_value", data_out, 16'hC100);
      idle(2);
      check("pending_refresh_write", 16'(dm_write), 16'h0001);
      check("pending_refresh_data", data_out, 16'hC200);
      idle(1);
      check("fresh_a_cleared", 16'(src_fresh[0]), 16'h0000);

      // Reset in the middle of a dwell on source R.
      stepToSel(2);
      auto_en = 1;
      for (int i = 0; i < 20 && !(!mShowing && mTimer == 5); i++) idle(1);
      doReset();
      check("reset_mid_strobe", 16'(dm_write), 16'h0000);
      check("reset_mid_sel", 16'(src_sel), 16'h0000);
      check("reset_mid_fresh", 16'(src_fresh), 16'h0000);
      auto_en = 0;
      idle(1);
      check("post_reset_write", 16'(dm_write), 16'h0001);
      check("post_reset_data", data_out, 16'h0000);

      // A new result while source A is shown.
      idle(3);
      applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h4110, 0);
      sawResult = 0;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         if (dm_write && data_out == 16'h4110 && src_sel == 2'd2) sawResult = 1;
      end
      check("result_priority_write", 16'(sawResult), 16'(PRIO));
      check("result_fresh", 16'(src_fresh[2]), 16'(!PRIO));
      doReset();
      idle(3);
      applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h4110, 1);
      idle(3);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
         if ($urandom_range(0, 599) == 0) doReset();
         applyStimulus($urandom_range(0, 11) == 0, 16'($urandom),
                       $urandom_range(0, 11) == 0, 16'($urandom),
                       $urandom_range(0, 15) == 0, 16'($urandom),
                       $urandom_range(0, 19) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
